// File: rtl/response_statistics_report_control_pkg.sv
// Shared types for the response-statistics report path: FSM states, counter index map,
// report beat layout and a helper that flattens the named counters into stats_in order.
package response_statistics_report_control_pkg;

    localparam int STATS_NUM_COUNTERS = 14;
    localparam int STATS_COUNT_W      = 32;
    localparam int REPORT_DATA_W      = 64;
    localparam int REPORT_IDX_W       = $clog2(STATS_NUM_COUNTERS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNAPSHOT,
        ST_SEND,
        ST_CLEAR,
        ST_DONE
    } report_state_e;

    localparam int STATS_IDX_DONE     = 0;
    localparam int STATS_IDX_READ     = 1;
    localparam int STATS_IDX_WRITE    = 2;
    localparam int STATS_IDX_TOUCH    = 3;
    localparam int STATS_IDX_FLUSHED  = 4;
    localparam int STATS_IDX_FAULT    = 5;
    localparam int STATS_IDX_FAILED   = 6;
    localparam int STATS_IDX_NRES     = 7;
    localparam int STATS_IDX_NLOCK    = 8;
    localparam int STATS_IDX_PAGED    = 9;
    localparam int STATS_IDX_AERROR   = 10;
    localparam int STATS_IDX_DERROR   = 11;
    localparam int STATS_IDX_RESERVED = 12;
    localparam int STATS_IDX_CYCLE    = 13;

    typedef struct packed {
        logic                     valid;
        logic                     last;
        logic [REPORT_IDX_W-1:0]  index;
        logic [REPORT_DATA_W-1:0] data;
    } response_statistics_report_t;

    typedef struct packed {
        logic [STATS_COUNT_W-1:0] done_count;
        logic [STATS_COUNT_W-1:0] read_count;
        logic [STATS_COUNT_W-1:0] write_count;
        logic [STATS_COUNT_W-1:0] touch_count;
        logic [STATS_COUNT_W-1:0] flushed_count;
        logic [STATS_COUNT_W-1:0] fault_count;
        logic [STATS_COUNT_W-1:0] failed_count;
        logic [STATS_COUNT_W-1:0] nres_count;
        logic [STATS_COUNT_W-1:0] nlock_count;
        logic [STATS_COUNT_W-1:0] paged_count;
        logic [STATS_COUNT_W-1:0] aerror_count;
        logic [STATS_COUNT_W-1:0] derror_count;
        logic [STATS_COUNT_W-1:0] reserved_count;
        logic [STATS_COUNT_W-1:0] cycle_count;
    } response_statistics_t;

    function automatic logic [STATS_NUM_COUNTERS*STATS_COUNT_W-1:0] pack_stats(
        input response_statistics_t s
    );
        logic [STATS_NUM_COUNTERS*STATS_COUNT_W-1:0] flat;
        flat = '0;
        flat[STATS_IDX_DONE*STATS_COUNT_W     +: STATS_COUNT_W] = s.done_count;
        flat[STATS_IDX_READ*STATS_COUNT_W     +: STATS_COUNT_W] = s.read_count;
        flat[STATS_IDX_WRITE*STATS_COUNT_W    +: STATS_COUNT_W] = s.write_count;
        flat[STATS_IDX_TOUCH*STATS_COUNT_W    +: STATS_COUNT_W] = s.touch_count;
        flat[STATS_IDX_FLUSHED*STATS_COUNT_W  +: STATS_COUNT_W] = s.flushed_count;
        flat[STATS_IDX_FAULT*STATS_COUNT_W    +: STATS_COUNT_W] = s.fault_count;
        flat[STATS_IDX_FAILED*STATS_COUNT_W   +: STATS_COUNT_W] = s.failed_count;
        flat[STATS_IDX_NRES*STATS_COUNT_W     +: STATS_COUNT_W] = s.nres_count;
        flat[STATS_IDX_NLOCK*STATS_COUNT_W    +: STATS_COUNT_W] = s.nlock_count;
        flat[STATS_IDX_PAGED*STATS_COUNT_W    +: STATS_COUNT_W] = s.paged_count;
        flat[STATS_IDX_AERROR*STATS_COUNT_W   +: STATS_COUNT_W] = s.aerror_count;
        flat[STATS_IDX_DERROR*STATS_COUNT_W   +: STATS_COUNT_W] = s.derror_count;
        flat[STATS_IDX_RESERVED*STATS_COUNT_W +: STATS_COUNT_W] = s.reserved_count;
        flat[STATS_IDX_CYCLE*STATS_COUNT_W    +: STATS_COUNT_W] = s.cycle_count;
        return flat;
    endfunction

endpackage

// File: rtl/response_statistics_report_control_if.sv
// Valid/ready report channel carrying one snapshot counter per beat.
interface response_statistics_report_control_if #(
    parameter int DATA_W = 64,
    parameter int IDX_W  = 4
) ();
    logic              report_valid;
    logic              report_ready;
    logic [DATA_W-1:0] report_data;
    logic [IDX_W-1:0]  report_index;
    logic              report_last;

    modport master (
        output report_valid,
        output report_data,
        output report_index,
        output report_last,
        input  report_ready
    );

    modport slave (
        input  report_valid,
        input  report_data,
        input  report_index,
        input  report_last,
        output report_ready
    );
endinterface

// File: rtl/response_statistics_report_control.sv
// Snapshots the response-statistics counters on request and streams them one word per beat,
// optionally pulsing a clear to the statistics block once the stream has completed.
module response_statistics_report_control
    import response_statistics_report_control_pkg::*;
#(
    parameter int NUM_COUNTERS = STATS_NUM_COUNTERS,
    parameter int COUNT_W      = STATS_COUNT_W,
    parameter int DATA_W       = REPORT_DATA_W
) (
    input  logic                            clock,
    input  logic                            rstn,
    input  logic                            enabled_in,
    input  logic [NUM_COUNTERS*COUNT_W-1:0] stats_in,
    input  logic                            start,
    input  logic                            clear_on_read,
    output logic                            stats_clear,
    output logic                            report_done,
    output logic                            busy,
    response_statistics_report_control_if.master report
);

    localparam int IDX_W = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COUNTERS - 1);

    if (COUNT_W > DATA_W || NUM_COUNTERS < 1) begin : g_bad_params
        $error("response_statistics_report_control: COUNT_W must be <= DATA_W and NUM_COUNTERS >= 1");
    end

    report_state_e      state_q, state_d;
    logic               enabled_q;
    logic               clr_q, clr_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               clear_q, clear_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               snap_we;
    logic               load_beat;
    logic [COUNT_W-1:0] snap_q [NUM_COUNTERS];
    logic [COUNT_W-1:0] snap_rd;

    for (genvar gi = 0; gi < NUM_COUNTERS; gi++) begin : g_snap
        always_ff @(posedge clock or negedge rstn) begin
            if (!rstn) begin
                snap_q[gi] <= '0;
            end else if (snap_we) begin
                snap_q[gi] <= stats_in[gi*COUNT_W +: COUNT_W];
            end
        end
    end

    always_comb begin
        snap_rd = '0;
        if (int'(ptr_q) < NUM_COUNTERS) begin
            snap_rd = snap_q[ptr_q];
        end
    end

    // The output stage behaves like a one-deep skid register: it refills whenever it is
    // empty or its beat is being taken, which gives one beat per cycle under constant ready.
    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        ptr_d     = ptr_q;
        valid_d   = valid_q;
        last_d    = last_q;
        index_d   = index_q;
        data_d    = data_q;
        clear_d   = 1'b0;
        done_d    = 1'b0;
        snap_we   = 1'b0;
        load_beat = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && enabled_q) begin
                    state_d = ST_SNAPSHOT;
                    clr_d   = clear_on_read;
                    ptr_d   = '0;
                end
            end
            ST_SNAPSHOT: begin
                snap_we = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (!valid_q) begin
                    load_beat = 1'b1;
                end else if (report.report_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        index_d = '0;
                        data_d  = '0;
                        if (clr_q) begin
                            state_d = ST_CLEAR;
                            clear_d = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        load_beat = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_beat) begin
            valid_d = 1'b1;
            data_d  = DATA_W'(snap_rd);
            index_d = ptr_q;
            last_d  = (ptr_q == LAST_IDX);
            ptr_d   = ptr_q + 1'b1;
        end

        // Losing enable abandons the report silently: no clear and no done.
        if (!enabled_q) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            index_d = '0;
            data_d  = '0;
            clear_d = 1'b0;
            done_d  = 1'b0;
            snap_we = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            enabled_q <= 1'b0;
            clr_q     <= 1'b0;
            ptr_q     <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            index_q   <= '0;
            data_q    <= '0;
            clear_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            enabled_q <= enabled_in;
            clr_q     <= clr_d;
            ptr_q     <= ptr_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            index_q   <= index_d;
            data_q    <= data_d;
            clear_q   <= clear_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign report.report_valid = valid_q;
    assign report.report_data  = data_q;
    assign report.report_index = index_q;
    assign report.report_last  = last_q;
    assign stats_clear         = clear_q;
    assign report_done         = done_q;
    assign busy                = busy_q;

endmodule

// File: tb/tb_response_statistics_report_control.sv
// Randomised bench for the statistics report sequencer, checked against a transaction-level model.
module tb_response_statistics_report_control;
    import response_statistics_report_control_pkg::*;

    localparam int N  = 14;
    localparam int CW = 32;
    localparam int DW = 64;
    localparam int IW = 4;

    logic          clock = 1'b0;
    logic          rstn = 1'b0;
    logic          enabled_in = 1'b0;
    logic          start = 1'b0;
    logic          clear_on_read = 1'b0;
    logic [N*CW-1:0] stats_in = '0;
    logic          stats_clear;
    logic          report_done;
    logic          busy;

    response_statistics_report_control_if #(.DATA_W(DW), .IDX_W(IW)) rif ();

    response_statistics_report_control dut (
        .clock         (clock),
        .rstn          (rstn),
        .enabled_in    (enabled_in),
        .stats_in      (stats_in),
        .start         (start),
        .clear_on_read (clear_on_read),
        .stats_clear   (stats_clear),
        .report_done   (report_done),
        .busy          (busy),
        .report        (rif.master)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit ready_mode = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: records accepted beats, pulses and the first valid cycle.
    logic [63:0] mon_data [$];
    int          mon_idx [$];
    bit          mon_last [$];
    int          mon_acc [$];
    int          done_cyc [$];
    int          clear_cyc [$];
    int          first_valid = -1;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic [IW-1:0] prev_idx;

    always @(negedge clock) begin
        if (rstn) begin
            if (prev_stall) begin
                chk("hold_valid", 64'(rif.report_valid), 64'd1);
                chk("hold_data", rif.report_data, prev_data);
                chk("hold_index", 64'(rif.report_index), 64'(prev_idx));
            end
            if (rif.report_valid && first_valid < 0) first_valid = cyc;
            if (rif.report_valid && rif.report_ready) begin
                mon_data.push_back(rif.report_data);
                mon_idx.push_back(int'(rif.report_index));
                mon_last.push_back(rif.report_last);
                mon_acc.push_back(cyc);
            end
            if (stats_clear) clear_cyc.push_back(cyc);
            if (report_done) done_cyc.push_back(cyc);
            prev_stall = rif.report_valid && !rif.report_ready;
            prev_data  = rif.report_data;
            prev_idx   = rif.report_index;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        rif.report_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            rif.report_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    logic [CW-1:0] cur [N];

    task automatic apply_stats();
        for (int k = 0; k < N; k++) stats_in[k*CW +: CW] = cur[k];
    endtask

    task automatic clear_mon();
        mon_data.delete(); mon_idx.delete(); mon_last.delete(); mon_acc.delete();
        done_cyc.delete(); clear_cyc.delete();
        first_valid = -1;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_valid"}, 64'(rif.report_valid), 64'd0);
        chk({tag, "_data"}, rif.report_data, 64'd0);
        chk({tag, "_index"}, 64'(rif.report_index), 64'd0);
        chk({tag, "_last"}, 64'(rif.report_last), 64'd0);
        chk({tag, "_clear"}, 64'(stats_clear), 64'd0);
        chk({tag, "_done"}, 64'(report_done), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // One full report: expected stream is the counter values present when SNAPSHOT samples.
    task automatic run_report(input string name, input bit clr, input bit inc, input bit rnd,
                              input bit restart);
        logic [CW-1:0] exp_snap [N];
        int start_cyc;
        bit got;
        int nb;
        for (int k = 0; k < N; k++) cur[k] = rnd ? CW'($urandom) : CW'(k + 100);
        apply_stats();
        clear_mon();
        @(posedge clock); #1;
        start = 1'b1; clear_on_read = clr; start_cyc = cyc;
        @(posedge clock); #1;
        start = 1'b0; clear_on_read = ~clr;
        if (inc) begin
            for (int k = 0; k < N; k++) cur[k] = cur[k] + 1'b1;
            apply_stats();
        end
        for (int k = 0; k < N; k++) exp_snap[k] = cur[k];
        got = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(posedge clock); #1;
            if (inc) begin
                for (int k = 0; k < N; k++) cur[k] = cur[k] + 1'b1;
                apply_stats();
            end
            start = restart && (c == 6);
            if (done_cyc.size() > 0) got = 1'b1;
        end
        start = 1'b0;
        repeat (restart ? 20 : 4) @(posedge clock);
        #1;
        chk({name, "_finished"}, 64'(got), 64'd1);
        nb = mon_data.size();
        chk({name, "_beats"}, 64'(nb), 64'(N));
        for (int i = 0; i < nb && i < N; i++) begin
            chk({name, "_data"}, mon_data[i], 64'(exp_snap[i]));
            chk({name, "_index"}, 64'(mon_idx[i]), 64'(i));
            chk({name, "_last"}, 64'(mon_last[i]), 64'(i == N - 1));
        end
        $display("%s: %0d beats, clear=%0b, dones=%0d clears=%0d", name, nb, clr,
                 done_cyc.size(), clear_cyc.size());
        chk({name, "_latency"}, 64'(first_valid - start_cyc), 64'd3);
        chk({name, "_done_n"}, 64'(done_cyc.size()), 64'd1);
        chk({name, "_clear_n"}, 64'(clear_cyc.size()), 64'(clr));
        if (!ready_mode && nb >= N)
            chk({name, "_b2b"}, 64'(mon_acc[N-1] - mon_acc[0]), 64'(N - 1));
        if (nb >= N && done_cyc.size() > 0) begin
            if (clr && clear_cyc.size() > 0) begin
                chk({name, "_clear_at"}, 64'(clear_cyc[0] - mon_acc[N-1]), 64'd1);
                chk({name, "_done_at"}, 64'(done_cyc[0] - mon_acc[N-1]), 64'd2);
            end else if (!clr) begin
                chk({name, "_done_at"}, 64'(done_cyc[0] - mon_acc[N-1]), 64'd1);
            end
        end
        chk({name, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic wait_index(input int idx, output bit found);
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(posedge clock); #1;
            if (rif.report_valid && int'(rif.report_index) == idx) found = 1'b1;
        end
    endtask

    initial begin
        bit found;

        repeat (3) @(posedge clock);
        #1;
        check_outputs_zero("reset");
        rstn = 1'b1;
        enabled_in = 1'b1;
        repeat (2) @(posedge clock);

        ready_mode = 1'b0;
        run_report("t1_plain", 1'b0, 1'b0, 1'b0, 1'b0);
        run_report("t2_clear", 1'b1, 1'b0, 1'b0, 1'b0);

        ready_mode = 1'b1;
        run_report("t3_stall", 1'b0, 1'b0, 1'b1, 1'b0);
        run_report("t3_stall_clr", 1'b1, 1'b0, 1'b1, 1'b0);
        run_report("t4_frozen", 1'b0, 1'b1, 1'b1, 1'b0);

        // Drop enable mid-stream: abandon quietly, then a fresh report starts from index 0.
        ready_mode = 1'b0;
        for (int k = 0; k < N; k++) cur[k] = CW'($urandom);
        apply_stats();
        clear_mon();
        @(posedge clock); #1;
        start = 1'b1; clear_on_read = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_index(5, found);
        chk("t5_reach5", 64'(found), 64'd1);
        enabled_in = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_outputs_zero("t5_abort");
        repeat (4) @(posedge clock);
        #1;
        chk("t5_no_done", 64'(done_cyc.size()), 64'd0);
        chk("t5_no_clear", 64'(clear_cyc.size()), 64'd0);
        $display("t5_abort: %0d beats before enable dropped", mon_data.size());
        enabled_in = 1'b1;
        repeat (2) @(posedge clock);
        run_report("t5_restart", 1'b1, 1'b0, 1'b1, 1'b0);

        run_report("t6_second_start", 1'b0, 1'b0, 1'b1, 1'b1);

        // Async reset mid-stream with clear requested: outputs drop at once, no clear follows.
        for (int k = 0; k < N; k++) cur[k] = CW'($urandom);
        apply_stats();
        clear_mon();
        @(posedge clock); #1;
        start = 1'b1; clear_on_read = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_index(3, found);
        chk("t6_reach3", 64'(found), 64'd1);
        rstn = 1'b0;
        #1;
        check_outputs_zero("t6_rst");
        @(posedge clock); #1;
        rstn = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        chk("t6_rst_no_clear", 64'(clear_cyc.size()), 64'd0);
        chk("t6_rst_no_done", 64'(done_cyc.size()), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        $display("t6_rst: reset applied mid-stream");
        run_report("t6_after_rst", 1'b0, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
